// File: rtl/divider_if.sv
// Handshake bundle for the iterative restoring divider: request side (ENABLE/DIV_0/DIV_1)
// and result side (READY/OUT/REM/DIV_BY_0/OUT_VALID).
interface divider_if #(
  parameter int unsigned WIDTH_0 = 16,
  parameter int unsigned WIDTH_1 = 16
);
  logic               ENABLE;
  logic [WIDTH_0-1:0] DIV_0;
  logic [WIDTH_1-1:0] DIV_1;
  logic               READY;
  logic [WIDTH_0-1:0] OUT;
  logic [WIDTH_1-1:0] REM;
  logic               DIV_BY_0;
  logic               OUT_VALID;

  modport master (
    output ENABLE, DIV_0, DIV_1,
    input  READY, OUT, REM, DIV_BY_0, OUT_VALID
  );

  modport slave (
    input  ENABLE, DIV_0, DIV_1,
    output READY, OUT, REM, DIV_BY_0, OUT_VALID
  );
endinterface

// File: rtl/divider.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, result held with a
// one-cycle OUT_VALID pulse. Initiation interval is WIDTH_0 + 2 cycles.
module divider #(
  parameter int unsigned WIDTH_0 = 16,
  parameter int unsigned WIDTH_1 = 16
) (
  input logic       CLK,
  input logic       RESET_N,
  divider_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH_0 + 1);
  localparam logic [CntW-1:0] LastStep = CntW'(WIDTH_0 - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH_0-1:0] q_q, q_d;
  logic [WIDTH_1-1:0] d_q, d_d;
  logic [WIDTH_1:0]   r_q, r_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [WIDTH_0-1:0] out_q, out_d;
  logic [WIDTH_1-1:0] rem_q, rem_d;
  logic               div_by_0_q, div_by_0_d;
  logic               out_valid_q, out_valid_d;

  logic [WIDTH_1:0]   trial;
  logic               fits;
  logic [WIDTH_1:0]   r_step;
  logic [WIDTH_0-1:0] q_step;

  // One restoring step; with d=0 it always "fits", giving all-ones and the dividend as remainder.
  always_comb begin
    trial  = {r_q[WIDTH_1-1:0], q_q[WIDTH_0-1]};
    fits   = (trial >= {1'b0, d_q});
    r_step = fits ? (trial - {1'b0, d_q}) : trial;
    q_step = WIDTH_0'({q_q, fits});
  end

  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    d_d         = d_q;
    r_d         = r_q;
    count_d     = count_q;
    out_d       = out_q;
    rem_d       = rem_q;
    div_by_0_d  = div_by_0_q;
    out_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.ENABLE) begin
          q_d     = bus.DIV_0;
          d_d     = bus.DIV_1;
          r_d     = '0;
          count_d = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        q_d     = q_step;
        r_d     = r_step;
        count_d = count_q + 1'b1;
        if (count_q == LastStep) begin
          out_d       = q_step;
          rem_d       = r_step[WIDTH_1-1:0];
          div_by_0_d  = (d_q == '0);
          out_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= StIdle;
      q_q         <= '0;
      d_q         <= '0;
      r_q         <= '0;
      count_q     <= '0;
      out_q       <= '0;
      rem_q       <= '0;
      div_by_0_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      d_q         <= d_d;
      r_q         <= r_d;
      count_q     <= count_d;
      out_q       <= out_d;
      rem_q       <= rem_d;
      div_by_0_q  <= div_by_0_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.READY     = (state_q == StIdle);
  assign bus.OUT       = out_q;
  assign bus.REM       = rem_q;
  assign bus.DIV_BY_0  = div_by_0_q;
  assign bus.OUT_VALID = out_valid_q;

endmodule
